// File: rtl/motor_pwm_driver_if.sv
// Motor PWM driver bus: speed level in, PWM pin and display status out.
//   i_motorState : 3-bit speed level (0 stop, 1-4 speed, 5-7 treated as stop)
//   o_pwm        : registered PWM pin
//   o_duty       : currently applied duty in ticks
//   o_ramping    : high while duty is moving toward the target
//   o_rampState  : 0 IDLE, 1 RAMP_UP, 2 RAMP_DOWN, 3 HOLD
// master = level source / status consumer, slave = the driver.
interface motor_pwm_driver_if;
  logic [2:0] i_motorState;
  logic       o_pwm;
  logic [6:0] o_duty;
  logic       o_ramping;
  logic [1:0] o_rampState;

  modport master (
    output i_motorState,
    input  o_pwm,
    input  o_duty,
    input  o_ramping,
    input  o_rampState
  );

  modport slave (
    input  i_motorState,
    output o_pwm,
    output o_duty,
    output o_ramping,
    output o_rampState
  );
endinterface

// File: rtl/motor_pwm_driver.sv
// Fan motor PWM driver. Turns a speed level into a PWM waveform, ramping the
// duty toward the level's target by at most RAMP_STEP ticks per PWM period.
// Stopping (level 0 or invalid 5-7) clears the duty on the next clock edge.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous, active-high reset
//   bus     : motor_pwm_driver_if.slave (level in; pwm, duty, ramp status out)
module motor_pwm_driver #(
  parameter int unsigned PRESCALE  = 100,
  parameter int unsigned PERIOD    = 100,
  parameter int unsigned RAMP_STEP = 5,
  parameter int unsigned DUTY_1    = 25,
  parameter int unsigned DUTY_2    = 50,
  parameter int unsigned DUTY_3    = 75,
  parameter int unsigned DUTY_4    = 100
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  motor_pwm_driver_if.slave    bus
);

  // A one-bit prescaler is kept for PRESCALE == 1; it simply stays at 0.
  localparam int unsigned   PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);
  localparam logic [6:0]    PerMax = 7'(PERIOD - 1);
  localparam logic [6:0]    Step   = 7'(RAMP_STEP);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StRampDown = 2'd2,
    StHold     = 2'd3
  } ramp_state_e;

  logic [PsW-1:0] ps_q, ps_d;
  logic [6:0]     per_q, per_d;
  logic [6:0]     duty_q, duty_d;
  logic           pwm_q, pwm_d;
  logic           ramping_q, ramping_d;
  ramp_state_e    state_q, state_d;

  logic           tick;
  logic           boundary;
  logic [6:0]     target;

  // Tick and PWM period counters.
  always_comb begin
    tick     = (ps_q == PsMax);
    ps_d     = tick ? '0 : ps_q + 1'b1;
    boundary = tick && (per_q == PerMax);
    per_d    = per_q;
    if (tick) begin
      per_d = (per_q == PerMax) ? '0 : per_q + 7'd1;
    end
  end

  // Level to target duty; invalid levels behave as stop.
  always_comb begin
    case (bus.i_motorState)
      3'd1:    target = 7'(DUTY_1);
      3'd2:    target = 7'(DUTY_2);
      3'd3:    target = 7'(DUTY_3);
      3'd4:    target = 7'(DUTY_4);
      default: target = '0;
    endcase
  end

  // Duty ramp, PWM compare and ramp status.
  always_comb begin
    duty_d = duty_q;
    if (target == '0) begin
      // Stop is immediate, not ramped.
      duty_d = '0;
    end else if (boundary) begin
      if (duty_q < target) begin
        duty_d = ((target - duty_q) > Step) ? duty_q + Step : target;
      end else if (duty_q > target) begin
        duty_d = ((duty_q - target) > Step) ? duty_q - Step : target;
      end
    end

    // Uses pre-edge count and duty, so the pin lags the duty by one cycle.
    pwm_d = (per_q < duty_q);

    // Status reflects the duty after this edge's update.
    if (duty_d < target) begin
      state_d = StRampUp;
    end else if (duty_d > target) begin
      state_d = StRampDown;
    end else if (target != '0) begin
      state_d = StHold;
    end else begin
      state_d = StIdle;
    end
    ramping_d = (state_d == StRampUp) || (state_d == StRampDown);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ps_q      <= '0;
      per_q     <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
      ramping_q <= 1'b0;
      state_q   <= StIdle;
    end else begin
      ps_q      <= ps_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
      ramping_q <= ramping_d;
      state_q   <= state_d;
    end
  end

  assign bus.o_pwm       = pwm_q;
  assign bus.o_duty      = duty_q;
  assign bus.o_ramping   = ramping_q;
  assign bus.o_rampState = state_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed ramp/stop/reset scenarios plus random
// level sequences checked cycle by cycle against a behavioural model.
module tb_motor_pwm_driver;

  localparam int unsigned PRESCALE  = 1;
  localparam int unsigned PERIOD    = 100;
  localparam int unsigned RAMP_STEP = 25;
  localparam int unsigned DUTY_1    = 25;
  localparam int unsigned DUTY_2    = 50;
  localparam int unsigned DUTY_3    = 75;
  localparam int unsigned DUTY_4    = 100;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  motor_pwm_driver_if bus ();

  motor_pwm_driver #(
    .PRESCALE  (PRESCALE),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP),
    .DUTY_1    (DUTY_1),
    .DUTY_2    (DUTY_2),
    .DUTY_3    (DUTY_3),
    .DUTY_4    (DUTY_4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  int         m_edges = 0;
  logic [6:0] m_duty  = '0;
  logic       m_pwm   = 1'b0;
  logic [1:0] m_state = 2'd0;

  function automatic int target_of(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return DUTY_1;
      3'd2:    return DUTY_2;
      3'd3:    return DUTY_3;
      3'd4:    return DUTY_4;
      default: return 0;
    endcase
  endfunction

  // With a one-cycle tick, the position in the PWM period is just the
  // number of clock edges since reset modulo PERIOD.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_edges = 0;
        m_duty  = '0;
        m_pwm   = 1'b0;
        m_state = 2'd0;
      end else begin
        int pos;
        int tgt;
        int d;
        pos   = m_edges % PERIOD;
        tgt   = target_of(bus.i_motorState);
        d     = int'(m_duty);
        m_pwm = (pos < d);
        if (tgt == 0) d = 0;
        else if (pos == PERIOD - 1) begin
          if (d < tgt) d = d + ((tgt - d < RAMP_STEP) ? tgt - d : RAMP_STEP);
          else if (d > tgt) d = d - ((d - tgt < RAMP_STEP) ? d - tgt : RAMP_STEP);
        end
        m_duty  = 7'(d);
        m_state = (d < tgt) ? 2'd1 : (d > tgt) ? 2'd2 : (tgt != 0) ? 2'd3 : 2'd0;
        m_edges = m_edges + 1;
      end
    end
  end

  // Waits (bounded) for o_duty to change; val = -1 if it never does.
  task automatic wait_duty_change(output int val);
    logic [6:0] prev;
    bit         done;
    prev = bus.o_duty;
    val  = -1;
    done = 1'b0;
    for (int i = 0; i < 250 && !done; i++) begin
      @(negedge clk);
      if (bus.o_duty !== prev) begin
        val  = int'(bus.o_duty);
        done = 1'b1;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    int bad;
    rst = 1'b1;
    bus.i_motorState = 3'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_pwm, bus.o_duty, bus.o_rampState, bus.o_ramping} !== 11'd0)
      $display("FAIL reset_outputs: pwm=%b duty=%0d state=%0d ramping=%b, want all 0",
               bus.o_pwm, bus.o_duty, bus.o_rampState, bus.o_ramping);
    else n_pass++;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ({bus.o_pwm, bus.o_duty, bus.o_rampState, bus.o_ramping} !== 11'd0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_hold: %0d cycles non-idle, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_ramp_up;
    int v;
    int hi;
    bus.i_motorState = 3'd2;
    @(negedge clk);
    n_checks++;
    if (bus.o_rampState !== 2'd1 || bus.o_ramping !== 1'b1)
      $display("FAIL up_state: state=%0d ramping=%b, want 1/1", bus.o_rampState, bus.o_ramping);
    else n_pass++;
    wait_duty_change(v);
    n_checks++;
    if (v != 25) $display("FAIL up_step1: duty=%0d, want 25", v); else n_pass++;
    wait_duty_change(v);
    n_checks++;
    if (v != 50) $display("FAIL up_step2: duty=%0d, want 50", v); else n_pass++;
    n_checks++;
    if (bus.o_rampState !== 2'd3 || bus.o_ramping !== 1'b0)
      $display("FAIL up_hold: state=%0d ramping=%b, want 3/0", bus.o_rampState, bus.o_ramping);
    else n_pass++;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_pwm === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 50) $display("FAIL pwm_50: high cycles=%0d, want 50", hi); else n_pass++;
  endtask

  task automatic test_level4;
    int v;
    int hi;
    bus.i_motorState = 3'd4;
    wait_duty_change(v);
    n_checks++;
    if (v != 75) $display("FAIL l4_step1: duty=%0d, want 75", v); else n_pass++;
    wait_duty_change(v);
    n_checks++;
    if (v != 100) $display("FAIL l4_step2: duty=%0d, want 100", v); else n_pass++;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_pwm === 1'b1) hi++;
    end
    n_checks++;
    if (hi != 100 || bus.o_rampState !== 2'd3)
      $display("FAIL pwm_full: high cycles=%0d state=%0d, want 100/3", hi, bus.o_rampState);
    else n_pass++;
  endtask

  task automatic test_ramp_down;
    int v;
    bus.i_motorState = 3'd1;
    @(negedge clk);
    n_checks++;
    if (bus.o_rampState !== 2'd2 || bus.o_ramping !== 1'b1)
      $display("FAIL down_state: state=%0d ramping=%b, want 2/1", bus.o_rampState, bus.o_ramping);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      wait_duty_change(v);
      n_checks++;
      if (v != 100 - 25 * k) $display("FAIL down_step%0d: duty=%0d, want %0d", k, v, 100 - 25 * k);
      else n_pass++;
    end
    n_checks++;
    if (bus.o_rampState !== 2'd3 || bus.o_ramping !== 1'b0)
      $display("FAIL down_hold: state=%0d ramping=%b, want 3/0", bus.o_rampState, bus.o_ramping);
    else n_pass++;
  endtask

  task automatic test_stop;
    logic [2:0] stop_lvls [3];
    bit         ok;
    stop_lvls[0] = 3'd0;
    stop_lvls[1] = 3'd5;
    stop_lvls[2] = 3'd7;
    for (int s = 0; s < 3; s++) begin
      bus.i_motorState = 3'd2;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clk);
        if (bus.o_duty === 7'd50 && bus.o_rampState === 2'd3) ok = 1'b1;
      end
      n_checks++;
      if (!ok) $display("FAIL stop_setup%0d: duty=%0d, want 50 in HOLD", s, bus.o_duty);
      else n_pass++;
      repeat ($urandom_range(10, 60)) @(negedge clk);
      bus.i_motorState = stop_lvls[s];
      @(negedge clk);
      n_checks++;
      if (bus.o_duty !== 7'd0 || bus.o_rampState !== 2'd0 || bus.o_ramping !== 1'b0)
        $display("FAIL stop_duty_lvl%0d: duty=%0d state=%0d ramping=%b, want 0/0/0",
                 stop_lvls[s], bus.o_duty, bus.o_rampState, bus.o_ramping);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.o_pwm !== 1'b0) $display("FAIL stop_pwm_lvl%0d: pwm=%b, want 0", stop_lvls[s], bus.o_pwm);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_ramp;
    int v;
    bus.i_motorState = 3'd3;
    wait_duty_change(v);
    wait_duty_change(v);
    n_checks++;
    if (v != 50 || bus.o_rampState !== 2'd1)
      $display("FAIL rst_setup: duty=%0d state=%0d, want 50/1", v, bus.o_rampState);
    else n_pass++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_pwm, bus.o_duty, bus.o_rampState, bus.o_ramping} !== 11'd0)
      $display("FAIL reset_async: pwm=%b duty=%0d state=%0d ramping=%b, want all 0",
               bus.o_pwm, bus.o_duty, bus.o_rampState, bus.o_ramping);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_duty_change(v);
      n_checks++;
      if (v != 25 * k) $display("FAIL restart_step%0d: duty=%0d, want %0d", k, v, 25 * k);
      else n_pass++;
    end
    n_checks++;
    if (bus.o_rampState !== 2'd3) $display("FAIL restart_hold: state=%0d, want 3", bus.o_rampState);
    else n_pass++;
  endtask

  task automatic test_random;
    int hold;
    int bad;
    for (int seg = 0; seg < 25; seg++) begin
      bus.i_motorState = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(20, 250);
      bad  = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (bus.o_duty !== m_duty || bus.o_pwm !== m_pwm || bus.o_rampState !== m_state ||
            bus.o_ramping !== (m_state == 2'd1 || m_state == 2'd2)) begin
          if (bad == 0)
            $display("FAIL random_seg%0d lvl=%0d: duty=%0d pwm=%b state=%0d ramping=%b, want %0d/%b/%0d",
                     seg, bus.i_motorState, bus.o_duty, bus.o_pwm, bus.o_rampState,
                     bus.o_ramping, m_duty, m_pwm, m_state);
          bad++;
        end
      end
      n_checks++;
      if (bad == 0) n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_motorState = 3'd0;
    test_reset();
    test_ramp_up();
    test_level4();
    test_ramp_down();
    test_stop();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
